// File: rtl/pipe_stage_reg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pipe_stage_reg : valid/ready pipeline register, optional skid    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module pipe_stage_reg #(
  parameter int CTRL_W = 11,
  parameter int DATA_W = 134,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              ready_q, ready_d;
  logic [CTRL_W-1:0] head_ctrl, skid_ctrl;
  logic [DATA_W-1:0] head_data, skid_data;
  logic              accept, drain;
  logic              load_head, promote, load_skid;

  assign out_valid = (state_q != EMPTY);
  assign accept    = in_valid & in_ready;
  assign drain     = out_valid & out_ready;
  // Bubbles carry no control so write enables cannot leak downstream.
  assign out_ctrl  = out_valid ? head_ctrl : '0;
  assign out_data  = head_data;

  always_comb begin
    state_d   = state_q;
    load_head = 1'b0;
    promote   = 1'b0;
    load_skid = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d   = ONE;
            load_head = 1'b1;
          end
        end
        ONE: begin
          if (accept && drain) begin
            load_head = 1'b1;
          end else if (accept) begin
            if (SKID != 0) begin
              state_d   = TWO;
              load_skid = 1'b1;
            end
          end else if (drain) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (drain) begin
            state_d = ONE;
            promote = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
    ready_d = (SKID != 0) ? (state_d != TWO) : 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= EMPTY;
      ready_q   <= 1'b0;
      head_ctrl <= '0;
      head_data <= '0;
      stall_cnt <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      if (load_head) begin
        head_ctrl <= in_ctrl;
        head_data <= in_data;
      end else if (promote) begin
        head_ctrl <= skid_ctrl;
        head_data <= skid_data;
      end
      if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + 1'b1;
    end
  end

  generate
    if (SKID != 0) begin : g_skid
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          skid_ctrl <= '0;
          skid_data <= '0;
        end else if (load_skid) begin
          skid_ctrl <= in_ctrl;
          skid_data <= in_data;
        end
      end
      assign in_ready = ready_q;
    end else begin : g_plain
      assign skid_ctrl = '0;
      assign skid_data = '0;
      // ready_q only masks the reset window; otherwise pass-through ready.
      assign in_ready  = ready_q & (~out_valid | out_ready);
    end
  endgenerate

endmodule
`default_nettype wire
